// File: rtl/rect_pkg.sv
// Shared encodings for the rectangle measurement block: FSM state codes,
// the state enum built from them, and the operation-select constants.
package rect_pkg;

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_REL  = 3'd2;
  localparam logic [2:0] ST_CALC = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
  localparam logic [2:0] ST_ACK  = 3'd5;

  localparam logic MODE_PERIM = 1'b0;
  localparam logic MODE_AREA  = 1'b1;

  typedef enum logic [2:0] {
    S_WAIT = ST_WAIT,
    S_LOAD = ST_LOAD,
    S_REL  = ST_REL,
    S_CALC = ST_CALC,
    S_OUT  = ST_OUT,
    S_ACK  = ST_ACK
  } state_e;

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-and-add multiplier: one partial product per cycle, W cycles
// while start_i is held; done_o/prod_o are valid combinationally on the last step.
module seq_mul #(
  parameter int W = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int SW = (W > 1) ? $clog2(W) : 1;
  localparam logic [SW-1:0] LAST = SW'(W - 1);

  logic [SW-1:0]  step_q, step_d;
  logic [2*W-1:0] acc_q, acc_d, addend;

  always_comb begin
    addend = b_i[step_q] ? ({{W{1'b0}}, a_i} << step_q) : '0;
    // Step 0 starts from zero so no explicit clear of the accumulator is needed.
    acc_d  = ((step_q == '0) ? '0 : acc_q) + addend;
    step_d = (start_i && (step_q != LAST)) ? step_q + SW'(1) : '0;
  end

  assign done_o = start_i && (step_q == LAST);
  assign prod_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      step_q <= '0;
      acc_q  <= '0;
    end else begin
      step_q <= step_d;
      if (start_i) acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rect_measure.sv
// Rectangle perimeter/area unit with active-low DAV / active-high RFD handshakes.
// Latency 3+release (perimeter) or 2+W+release (area); one operation in flight.
module rect_measure
  import rect_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clock,
  input  logic           _reset,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  input  logic           _dav,
  output logic           rfd,
  output logic [2*W-1:0] p,
  output logic           _dav_out,
  input  logic           rfd_out
);

  state_e         state_q;
  logic [W-1:0]   a_q, b_q;
  logic           mode_q;
  logic [2*W-1:0] p_q;
  logic           rfd_q, dav_out_n_q;

  logic [2*W-1:0] perim_d, prod;
  logic           mul_start, mul_done;

  assign perim_d   = ({{W{1'b0}}, a_q} + {{W{1'b0}}, b_q}) << 1;
  assign mul_start = (state_q == S_CALC) && (mode_q == MODE_AREA);

  seq_mul #(.W(W)) u_mul (
    .clk_i  (clock),
    .rst_ni (_reset),
    .start_i(mul_start),
    .a_i    (a_q),
    .b_i    (b_q),
    .done_o (mul_done),
    .prod_o (prod)
  );

  always_ff @(posedge clock) begin
    if (!_reset) begin
      state_q     <= S_WAIT;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= MODE_PERIM;
      p_q         <= '0;
      rfd_q       <= 1'b1;
      dav_out_n_q <= 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          rfd_q       <= 1'b1;
          dav_out_n_q <= 1'b1;
          if (!_dav) state_q <= S_LOAD;
        end
        S_LOAD: begin
          a_q     <= a;
          b_q     <= b;
          mode_q  <= mode;
          rfd_q   <= 1'b0;
          state_q <= S_REL;
        end
        S_REL: begin
          if (_dav) state_q <= S_CALC;
        end
        S_CALC: begin
          if (mode_q == MODE_PERIM) begin
            p_q         <= perim_d;
            dav_out_n_q <= 1'b0;
            state_q     <= S_OUT;
          end else if (mul_done) begin
            p_q         <= prod;
            dav_out_n_q <= 1'b0;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (!rfd_out) begin
            dav_out_n_q <= 1'b1;
            state_q     <= S_ACK;
          end
        end
        S_ACK: begin
          if (rfd_out) begin
            rfd_q   <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign rfd      = rfd_q;
  assign p        = p_q;
  assign _dav_out = dav_out_n_q;

endmodule

// File: tb/tb_rect_measure.sv
// Bench for rect_measure: directed table, handshake corner cases and random
// operations checked against a plain-arithmetic reference.
module tb_rect_measure;

  localparam int W = 4;

  logic           clock = 1'b0;
  logic           _reset;
  logic [W-1:0]   a, b;
  logic           mode;
  logic           _dav;
  logic           rfd;
  logic [2*W-1:0] p;
  logic           _dav_out;
  logic           rfd_out;

  int cyc  = 0;
  int ncmp = 0;
  int nerr = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rect_measure #(.W(W)) dut (
    .clock   (clock),
    ._reset  (_reset),
    .a       (a),
    .b       (b),
    .mode    (mode),
    ._dav    (_dav),
    .rfd     (rfd),
    .p       (p),
    ._dav_out(_dav_out),
    .rfd_out (rfd_out)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           mode;
    int             rel;
    logic [2*W-1:0] exp_p;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic m, input int rel);
    return (m ? 2 + W : 3) + rel;
  endfunction

  function automatic logic [2*W-1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                           input logic tm);
    int x, y, r;
    x = int'(ta);
    y = int'(tb_);
    r = tm ? x * y : 2 * (x + y);
    return (2*W)'(r);
  endfunction

  // One full operation: present operands, release _dav after rel extra cycles,
  // wait for the result, hold it for `hold` cycles, then complete the handshake.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tm, input int rel, input int hold,
                        input logic [W-1:0] la, input logic [W-1:0] lb,
                        input logic [2*W-1:0] exp_p);
    int c0, n;
    logic [2*W-1:0] p0, pg;
    bit early, stable;
    chk({nm, " rfd idle"}, 32'(rfd), 32'd1);
    p0 = p;
    a = ta; b = tb_; mode = tm; _dav = 1'b0;
    @(posedge clock); #1;
    c0 = cyc;
    @(posedge clock); #1;
    chk({nm, " rfd after load"}, 32'(rfd), 32'd0);
    a = la; b = lb; mode = ~tm;
    repeat (rel) begin
      @(posedge clock); #1;
    end
    _dav = 1'b1;
    n = 0;
    early = 1'b0;
    while (_dav_out && n < 100) begin
      if (p !== p0) early = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    chk({nm, " result in time"}, 32'(n < 100), 32'd1);
    chk({nm, " p held until done"}, 32'(early), 32'd0);
    chk({nm, " p"}, 32'(p), 32'(exp_p));
    chk({nm, " latency"}, 32'(cyc - c0), 32'(exp_lat(tm, rel)));
    pg = p;
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == 2) _dav = 1'b0;
        if (i == 3) _dav = 1'b1;
        @(posedge clock); #1;
        if (_dav_out !== 1'b0 || p !== pg || rfd !== 1'b0) stable = 1'b0;
      end
      _dav = 1'b1;
      chk({nm, " hold stable"}, 32'(stable), 32'd1);
    end
    rfd_out = 1'b0;
    @(posedge clock); #1;
    chk({nm, " dav_out released"}, 32'(_dav_out), 32'd1);
    chk({nm, " rfd low in ack"}, 32'(rfd), 32'd0);
    rfd_out = 1'b1;
    @(posedge clock); #1;
    chk({nm, " rfd back"}, 32'(rfd), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rm;
    int rr, rh;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  mode: 1'b0, rel: 0, exp_p: 8'd16};
    vecs[1] = '{a: 4'd15, b: 4'd15, mode: 1'b1, rel: 0, exp_p: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  mode: 1'b1, rel: 0, exp_p: 8'd0};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  mode: 1'b0, rel: 0, exp_p: 8'd18};
    vecs[4] = '{a: 4'd7,  b: 4'd0,  mode: 1'b0, rel: 2, exp_p: 8'd14};
    vecs[5] = '{a: 4'd15, b: 4'd15, mode: 1'b0, rel: 1, exp_p: 8'd60};
    vecs[6] = '{a: 4'd1,  b: 4'd1,  mode: 1'b1, rel: 3, exp_p: 8'd1};
    vecs[7] = '{a: 4'd12, b: 4'd10, mode: 1'b1, rel: 0, exp_p: 8'd120};

    _reset = 1'b0; _dav = 1'b1; rfd_out = 1'b1;
    a = '0; b = '0; mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset p", 32'(p), 32'd0);
    chk("reset rfd", 32'(rfd), 32'd1);
    chk("reset dav_out", 32'(_dav_out), 32'd1);
    _reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle p", 32'(p), 32'd0);
    chk("idle rfd", 32'(rfd), 32'd1);
    chk("idle dav_out", 32'(_dav_out), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].rel, 0,
             W'($urandom), W'($urandom), vecs[i].exp_p);
    end

    // Operand change while upstream still holds _dav low.
    run_op("relchg", 4'd3, 4'd4, 1'b0, 2, 0, 4'd7, 4'd4, 8'd14);

    // Long downstream stall with a stray _dav pulse during it.
    run_op("stall", 4'd5, 4'd6, 1'b1, 0, 10, 4'd0, 4'd0, 8'd30);
    repeat (3) @(posedge clock);
    #1;
    chk("stall no spurious op", 32'(_dav_out), 32'd1);
    chk("stall p kept", 32'(p), 32'd30);

    // Reset in the middle of an area calculation.
    a = 4'd15; b = 4'd15; mode = 1'b1; _dav = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    _dav = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    _reset = 1'b0;
    @(posedge clock); #1;
    chk("midcalc reset p", 32'(p), 32'd0);
    chk("midcalc reset rfd", 32'(rfd), 32'd1);
    chk("midcalc reset dav_out", 32'(_dav_out), 32'd1);
    _reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("midcalc result discarded", 32'(_dav_out), 32'd1);
    run_op("after reset perim", 4'd2, 4'd6, 1'b0, 0, 0, 4'd9, 4'd9, 8'd16);
    run_op("after reset area", 4'd3, 4'd4, 1'b1, 0, 0, 4'd9, 4'd9, 8'd12);

    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rm = 1'($urandom_range(0, 1));
      rr = $urandom_range(0, 2);
      rh = $urandom_range(0, 4);
      run_op($sformatf("rnd%0d", i), ra, rb, rm, rr, rh, W'($urandom), W'($urandom),
             model(ra, rb, rm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/rect_measure.md
RECT_MEASURE -- requirements
Module: rect_measure

Interface
REQ-001 SHALL have parameter: W, 4, side width in bits (legal range 2..16).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: _reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: a  input  W  side a, valid while _dav==0.
REQ-005 SHALL have port: b  input  W  side b, valid while _dav==0.
REQ-006 SHALL have port: mode  input  1  operation select: 0 perimeter, 1 area; valid while _dav==0.
REQ-007 SHALL have port: _dav  input  1  upstream data-available, active-low.
REQ-008 SHALL have port: rfd  output  1  ready-for-data to upstream, active-high.
REQ-009 SHALL have port: p  output  2W  result register.
REQ-010 SHALL have port: _dav_out  output  1  downstream data-available, active-low.
REQ-011 SHALL have port: rfd_out  input  1  downstream ready-for-data, active-high.

Function
REQ-012 SHALL implement FSM states: WAIT, LOAD, REL, CALC, OUT, ACK.
REQ-013 WAIT: rfd=1, _dav_out=1; on edge with _dav==0 go to LOAD, else stay.
REQ-014 LOAD: capture a, b, mode into internal registers; rfd<=0; go to REL.
REQ-015 REL: stay while _dav==0, with no recapture; on _dav==1 go to CALC.
REQ-016 CALC, mode 0: result = 2*(A+B), zero-extended to 2W; written to p on the single CALC edge; go to OUT.
REQ-017 CALC, mode 1: A*B by shift-and-add over exactly W CALC cycles using a step counter; p written on the last step only; go to OUT.
REQ-018 p SHALL hold its previous value during WAIT, LOAD, REL and all non-final CALC cycles.
REQ-019 OUT: _dav_out<=0 on entry; stay while rfd_out==1; on rfd_out==0 go to ACK with _dav_out<=1.
REQ-020 ACK: stay while rfd_out==0; on rfd_out==1 go to WAIT with rfd<=1.
REQ-021 rfd SHALL be 0 from the LOAD edge until the ACK->WAIT edge; no new operand is accepted while a result is pending.
REQ-022 Widths: perimeter ≤ 4*(2^W-1) and area ≤ (2^W-1)^2 both fit 2W bits; arithmetic is unsigned; no overflow is possible.
REQ-023 Zero operands SHALL give: area 0; perimeter 2*(other side).
REQ-024 Input changes on a/b/mode after LOAD SHALL NOT affect the result.
REQ-025 Latency from the first edge sampling _dav==0 to _dav_out==0 SHALL be 3 + release cycles for perimeter and 2 + W + release cycles for area.

Reset
REQ-026 At a rising edge with _reset==0: state=WAIT, p=0, rfd=1, _dav_out=1, operand registers=0, step counter=0.
REQ-027 Reset SHALL take priority over every transition, including mid-CALC and OUT/ACK; any pending result is discarded.
REQ-028 Outputs SHALL change only on clock edges; _reset SHALL have no asynchronous effect.

Structure
REQ-029 Shared package rect_pkg SHALL hold the state encoding localparams (3-bit) and the mode constants MODE_PERIM=0 and MODE_AREA=1.
REQ-030 The shift-and-add multiplier SHALL be sub-module seq_mul (parameter W; start/done; 2W product); the perimeter logic stays inline.
REQ-031 All widths SHALL derive from W; no hard-coded 4/8.

Verification (W=4)
REQ-032 Reset pulse, then idle -> p=0, rfd=1, _dav_out=1.
REQ-033 a=3, b=5, mode=0, full handshake -> p=16, _dav_out low 3 edges after _dav sampled low, with immediate _dav release.
REQ-034 a=15, b=15, mode=1 -> p=225 after 4 CALC cycles; a=0, b=9, mode=1 -> p=0.
REQ-035 Hold rfd_out=1 for 10 cycles after _dav_out falls -> _dav_out stays 0, p stable, rfd stays 0; a second _dav low pulse is ignored.
REQ-036 Change a/b during REL (a=3→7) -> result uses the captured value 3.
REQ-037 Assert _reset during CALC of an area operation -> next edge gives state WAIT, p=0, rfd=1; a subsequent a=2, b=6, mode=0 operation gives p=16.
